// File: rtl/regfile_ctrl_pkg.sv
// Shared encodings for the register-file access controller: port ops, PC auto-step
// modes and the sequencer state type.
package regfile_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_RD   = 2'b00,
        OP_WR   = 2'b01,
        OP_LDPC = 2'b10,
        OP_STEP = 2'b11
    } op_e;

    localparam logic [1:0] PCM_INC  = 2'b00;
    localparam logic [1:0] PCM_DEC  = 2'b01;
    localparam logic [1:0] PCM_HOLD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP,
        S_STEP
    } state_e;

    // Any mode with the upper bit set freezes auto-stepping.
    function automatic logic pcm_is_hold(input logic [1:0] mode);
        return (mode & PCM_HOLD) != 2'b00;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: counts 0..TICK_DIV-1 and flags the terminal count as a
// one-cycle tick.
module tick_prescaler #(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic clr_n,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Two-port req/gnt/done arbiter and sequencer for the shared register file and PC,
// with prescaled PC auto-steps issued whenever no request is waiting.
module regfile_access_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 100000,
    parameter int DW       = 8
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          req0,
    input  logic          req1,
    input  logic [1:0]    op0,
    input  logic [1:0]    op1,
    input  logic [1:0]    addr0,
    input  logic [1:0]    addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          done0,
    output logic          done1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    input  logic [1:0]    pc_mode,
    output logic [1:0]    rf_ra,
    output logic          rf_we,
    output logic [DW-1:0] rf_wdata,
    input  logic [DW-1:0] rf_rdata,
    output logic          pc_ld,
    output logic          pc_inc,
    output logic          pc_dec,
    output logic          busy,
    output logic          tick_miss
);

    state_e        state, state_n;
    logic          win, win_n;
    logic          last;
    op_e           op_q;
    logic [1:0]    op_sel;
    logic [1:0]    ra_n;
    logic [DW-1:0] wd_n;
    logic          we_n, ld_n, inc_n, dec_n;
    logic          tick, pend;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk   (clk),
        .clr_n (clr_n),
        .tick  (tick)
    );

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        state_n = state;
        win_n   = win;
        op_sel  = op0;
        ra_n    = rf_ra;
        wd_n    = rf_wdata;
        we_n    = 1'b0;
        ld_n    = 1'b0;
        inc_n   = 1'b0;
        dec_n   = 1'b0;
        case (state)
            S_IDLE: begin
                if (req0 || req1) begin
                    // On a tie the port not served last wins.
                    win_n  = (req0 && req1) ? ~last : req1;
                    op_sel = win_n ? op1 : op0;
                    ra_n   = win_n ? addr1 : addr0;
                    wd_n   = win_n ? wdata1 : wdata0;
                    case (op_sel)
                        OP_WR:   we_n = 1'b1;
                        OP_LDPC: ld_n = 1'b1;
                        OP_STEP: begin
                            inc_n = ~pc_mode[0];
                            dec_n = pc_mode[0];
                        end
                        default: ;
                    endcase
                    state_n = S_EXEC;
                end else if ((pend || tick) && !pcm_is_hold(pc_mode)) begin
                    inc_n   = (pc_mode == PCM_INC);
                    dec_n   = (pc_mode == PCM_DEC);
                    state_n = S_STEP;
                end
            end
            S_EXEC:  state_n = S_RESP;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            // NOTE: rdata is reset too; it is a pair of visible output registers, not a memory.
            rdata0    <= '0;
            rdata1    <= '0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            rf_ra     <= '0;
            rf_wdata  <= '0;
            rf_we     <= 1'b0;
            pc_ld     <= 1'b0;
            pc_inc    <= 1'b0;
            pc_dec    <= 1'b0;
            win       <= 1'b0;
            last      <= 1'b1;
            op_q      <= OP_RD;
            pend      <= 1'b0;
            tick_miss <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            win      <= win_n;
            rf_ra    <= ra_n;
            rf_wdata <= wd_n;
            rf_we    <= we_n;
            pc_ld    <= ld_n;
            pc_inc   <= inc_n;
            pc_dec   <= dec_n;
            gnt0     <= (state_n == S_EXEC || state_n == S_RESP) && !win_n;
            gnt1     <= (state_n == S_EXEC || state_n == S_RESP) && win_n;
            done0    <= (state_n == S_RESP) && !win_n;
            done1    <= (state_n == S_RESP) && win_n;

            if (state == S_IDLE && state_n == S_EXEC) op_q <= op_e'(op_sel);

            if (state == S_EXEC && op_q == OP_RD) begin
                if (win) rdata1 <= rf_rdata;
                else     rdata0 <= rf_rdata;
            end

            if (state == S_RESP) last <= win;

            // A tick landing while one still waits is dropped and flagged.
            if (tick) begin
                pend <= 1'b1;
                if (pend && state != S_STEP) tick_miss <= 1'b1;
            end else if (state == S_STEP) begin
                pend <= 1'b0;
            end
        end
    end

endmodule

// File: doc/regfile_access_ctrl.md
# regfile_access_ctrl

Sequencer and arbiter for the shared 4×8 register file (R0–R3) and 8-bit PC. Two requesters share one single-port datapath through a req/gnt/done handshake: the keypad entry path and the auto-step/script path. The block also issues prescaled PC auto-steps when no request is pending. It drives only control strobes; register and PC storage stay in the datapath.

## Interface
- TICK_DIV, 100000: clk cycles per PC auto-step tick (≥2)
- DW, 8: data width
- clk  in  1  single clock, all state updates on rising edge
- clr_n  in  1  asynchronous, active-low reset
- req0 / req1  in  1  access request, port 0 / port 1
- op0 / op1  in  2  00 read Rn, 01 write Rn, 10 load PC, 11 step PC
- addr0 / addr1  in  2  register index; ignored for PC ops
- wdata0 / wdata1  in  DW  write/load data
- gnt0 / gnt1  out  1  port owns datapath
- done0 / done1  out  1  one-cycle completion pulse
- rdata0 / rdata1  out  DW  read result, held until that port's next read completes
- pc_mode  in  2  auto-step: 00 inc, 01 dec, 1x hold
- rf_ra  out  2  register select to datapath
- rf_we  out  1  register write strobe
- rf_wdata  out  DW  register/PC write data
- rf_rdata  in  DW  combinational read of R[rf_ra]
- pc_ld / pc_inc / pc_dec  out  1  PC load / +1 / −1 strobes, mutually exclusive
- busy  out  1  FSM not in IDLE
- tick_miss  out  1  sticky; a tick arrived while one was already pending

## Operation
- FSM states: IDLE, EXEC, RESP, STEP.
- IDLE, with any req high: select a winner and go to EXEC. Both high: the port not served last wins. The last-served pointer resets to 1, so port 0 wins the first tie.
- IDLE, no req, tick pending, pc_mode[1]=0: go to STEP.
- EXEC, one cycle: drive rf_ra=addr and rf_wdata=wdata. Then by op:
  - 01: rf_we=1.
  - 10: pc_ld=1.
  - 11: pc_inc if pc_mode[0]=0, else pc_dec.
  - 00: capture rf_rdata into rdata of the winner at end of cycle.
- RESP, one cycle: done pulses for the winner; update the pointer; return to IDLE.
- STEP, one cycle: pc_inc or pc_dec per pc_mode; clear pending; return to IDLE. No gnt or done.
- gnt asserts from the EXEC cycle through RESP only.
- Prescaler: counts 0..TICK_DIV−1 and wraps. At terminal count it sets tick pending. If pending is already set, it sets tick_miss instead, and that tick is dropped.
- Ticks pending while pc_mode is hold stay pending until the mode leaves hold.
- Requests always beat pending ticks.

## Timing
- Latency: req sampled high in IDLE at edge k → EXEC cycle k+1 (strobe, gnt) → RESP cycle k+2 (done, rdata valid) → IDLE at k+3. Throughput: one access per 3 cycles.
- req held through RESP means a new request is sampled at k+3. The requester drops req in the done cycle to avoid a repeat.
- req deasserted during EXEC/RESP: the operation still completes and done still pulses.
- Request arriving during STEP: served on the next IDLE evaluation.
- Strobes are registered: at most one of rf_we/pc_ld/pc_inc/pc_dec is high in any cycle.
- PC arithmetic wraps mod 2^DW in the datapath. The block never suppresses a step at 0xFF or 0x00.
- Reset, including mid-operation:
  - outputs: gnt, done, rdata, all strobes, rf_ra, rf_wdata, busy and tick_miss all return to 0.
  - internal: state returns to IDLE, prescaler to 0, tick pending to 0, pointer to 1.
  - an access interrupted by reset produces no done.

## Structure
- Shared package regfile_ctrl_pkg holds: op encodings (OP_RD, OP_WR, OP_LDPC, OP_STEP), pc_mode encodings, and the FSM state typedef.
- Sub-module tick_prescaler(TICK_DIV) holds the counter and produces a one-cycle tick.
- The arbiter, FSM and strobe registers stay in the top module.

## Test plan
- TICK_DIV=4: req0 write, addr=2, wdata=0x5A → gnt0 one cycle later; rf_we=1 with rf_ra=2, rf_wdata=0x5A; done0 the cycle after; busy low 3 cycles after req.
- req0 and req1 both held high with reads; datapath returns 0x11 for R1 and 0x22 for R3 → grants alternate 0,1,0,1; rdata0=0x11, rdata1=0x22.
- TICK_DIV=4, pc_mode=00, no requests → pc_inc pulse every 4 cycles, each 1 cycle after the tick. With pc_mode=10 and two ticks → no strobes; tick_miss=1.
- Tick pending plus req1 load PC 0x7F in the same cycle → pc_ld with 0x7F first, done1, then the pc_inc STEP.
- clr_n low during EXEC of a write → rf_we drops immediately; no done. After release, a fresh req0/req1 tie grants port 0.
- req0 with op=11 and pc_mode=01 → pc_dec (not pc_inc), done0.
